vape_irq_dma_multi: RTL and testbench

- Parametrised successor to the single-region VAPE IRQ/DMA executable-region monitor.
- Watches N independent executable regions (ER) against the openMSP430 PC, irq and dma_en.
- Keeps a registered per-region EXEC/ABORT state instead of a combinational latch, with a per-region IRQ-tolerance mode, latched abort cause and a saturating abort counter.
- Sits beside the other VAPE hardware monitors; exec[i] feeds the per-region attestation EXEC flag.

---
 rtl/vape_irq_dma_pkg.sv | 15 +
 rtl/vape_irq_dma_multi_if.sv | 30 +++
 rtl/vape_er_monitor.sv | 77 +++++++
 rtl/vape_irq_dma_multi.sv | 60 ++++++
 tb/tb_vape_irq_dma_multi.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vape_irq_dma_pkg.sv
// Shared state and abort-cause encodings for the VAPE IRQ/DMA region monitors.
package vape_irq_dma_pkg;

  typedef enum logic {
    ST_ABORT = 1'b0,
    ST_EXEC  = 1'b1
  } er_state_e;

  // Cause bits are {dma, irq}, so the codes can be built directly from the events.
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_IRQ  = 2'b01;
  localparam logic [1:0] CAUSE_DMA  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/vape_irq_dma_multi_if.sv
// CPU-side signals into the multi-region monitor and its status outputs.
interface vape_irq_dma_multi_if #(
  parameter int N_REGIONS = 2,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 8
) ();

  logic [ADDR_W-1:0]           pc;
  logic                        irq;
  logic                        dma_en;
  logic [N_REGIONS*ADDR_W-1:0] er_min;
  logic [N_REGIONS*ADDR_W-1:0] er_max;
  logic [N_REGIONS-1:0]        irq_allow;
  logic                        cnt_clr;
  logic [N_REGIONS-1:0]        exec;
  logic                        any_exec;
  logic [N_REGIONS*2-1:0]      abort_cause;
  logic [CNT_W-1:0]            abort_cnt;

  modport master (
    output pc, irq, dma_en, er_min, er_max, irq_allow, cnt_clr,
    input  exec, any_exec, abort_cause, abort_cnt
  );

  modport slave (
    input  pc, irq, dma_en, er_min, er_max, irq_allow, cnt_clr,
    output exec, any_exec, abort_cause, abort_cnt
  );

endinterface

// File: rtl/vape_er_monitor.sv
// One executable-region monitor: bound compare, EXEC/ABORT FSM, exec flag, abort cause.
//
//   state    | meaning
//   ST_ABORT | region not validly entered, or aborted since the last entry
//   ST_EXEC  | region entered at er_min with no DMA/irq violation since
module vape_er_monitor
  import vape_irq_dma_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] er_min,
  input  logic [ADDR_W-1:0] er_max,
  input  logic              irq,
  input  logic              dma_en,
  input  logic              irq_allow,
  output logic              exec,
  output logic [1:0]        abort_cause,
  output logic              abort_evt
);

  er_state_e  state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       valid, in_er, irq_hit, viol, entry;

  // Region compare and violation/entry qualification for the current cycle.
  always_comb begin
    valid   = (er_min <= er_max);
    in_er   = valid && (pc >= er_min) && (pc <= er_max);
    irq_hit = irq && !irq_allow;
    viol    = in_er && (dma_en || irq_hit);
    entry   = valid && (pc == er_min) && !viol;
  end

  // Next state and cause. Only a violation counts as an abort event; an
  // invalidated region just drops back to ABORT and keeps its last cause.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    abort_evt = 1'b0;
    if (state_q == ST_ABORT) begin
      if (entry) begin
        state_d = ST_EXEC;
        cause_d = CAUSE_NONE;
      end
    end else begin
      if (viol) begin
        state_d   = ST_ABORT;
        cause_d   = {dma_en, irq_hit};
        abort_evt = 1'b1;
      end
    end
    if (!valid) state_d = ST_ABORT;
  end

  // State and cause registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ABORT;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // exec reacts in the same cycle as the event; held low during reset.
  always_comb begin
    exec = rst_n && valid &&
           (((state_q == ST_EXEC) && !viol) || ((state_q == ST_ABORT) && entry));
  end

  assign abort_cause = cause_q;

endmodule

// File: rtl/vape_irq_dma_multi.sv
// N-region VAPE IRQ/DMA monitor: per-region monitors plus shared abort counter.
module vape_irq_dma_multi
  import vape_irq_dma_pkg::*;
#(
  parameter int N_REGIONS = 2,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  vape_irq_dma_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_REGIONS-1:0]   exec;
  logic [N_REGIONS-1:0]   abort_evt;
  logic [N_REGIONS*2-1:0] cause;
  logic [CNT_W-1:0]       abort_cnt_q, abort_cnt_d;
  logic                   abort_any;

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    vape_er_monitor #(.ADDR_W(ADDR_W)) u_mon (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (bus.pc),
      .er_min      (bus.er_min[g*ADDR_W +: ADDR_W]),
      .er_max      (bus.er_max[g*ADDR_W +: ADDR_W]),
      .irq         (bus.irq),
      .dma_en      (bus.dma_en),
      .irq_allow   (bus.irq_allow[g]),
      .exec        (exec[g]),
      .abort_cause (cause[g*2 +: 2]),
      .abort_evt   (abort_evt[g])
    );
  end

  // Saturating abort counter; simultaneous aborts count once, clear then count.
  always_comb begin
    abort_any   = |abort_evt;
    abort_cnt_d = abort_cnt_q;
    if (bus.cnt_clr) begin
      abort_cnt_d = abort_any ? CNT_W'(1) : '0;
    end else if (abort_any && (abort_cnt_q != CNT_MAX)) begin
      abort_cnt_d = abort_cnt_q + CNT_W'(1);
    end
  end

  // Counter register; reset wins over cnt_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) abort_cnt_q <= '0;
    else        abort_cnt_q <= abort_cnt_d;
  end

  assign bus.exec        = exec;
  assign bus.any_exec    = |exec;
  assign bus.abort_cause = cause;
  assign bus.abort_cnt   = abort_cnt_q;

endmodule

// File: tb/tb_vape_irq_dma_multi.sv
// Directed bench for vape_irq_dma_multi with N=2, ADDR_W=16, CNT_W=8.
module tb_vape_irq_dma_multi;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vape_irq_dma_multi_if #(.N_REGIONS(2), .ADDR_W(16), .CNT_W(8)) bus ();

  vape_irq_dma_multi #(.N_REGIONS(2), .ADDR_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.pc = 16'hE000;
    tick();
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL reset_exec: got %b expected 00", bus.exec); end
    n_checks++;
    if (bus.any_exec !== 1'b0) begin n_fail++; $display("FAIL reset_any_exec: got %b expected 0", bus.any_exec); end
    n_checks++;
    if (bus.abort_cause !== 4'b0000) begin n_fail++; $display("FAIL reset_cause: got %b expected 0000", bus.abort_cause); end
    n_checks++;
    if (bus.abort_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.abort_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_entry_run();
    bus.pc = 16'hE000;
    #1;
    n_checks++;
    if (bus.exec !== 2'b01) begin n_fail++; $display("FAIL entry_exec: got %b expected 01", bus.exec); end
    n_checks++;
    if (bus.any_exec !== 1'b1) begin n_fail++; $display("FAIL entry_any_exec: got %b expected 1", bus.any_exec); end
    tick();
    for (int a = 1; a <= 255; a++) begin
      bus.pc = 16'hE000 + a[15:0];
      #1;
      n_checks++;
      if (bus.exec !== 2'b01) begin n_fail++; $display("FAIL walk_exec pc=%h: got %b expected 01", bus.pc, bus.exec); end
      tick();
    end
    n_checks++;
    if (bus.abort_cnt !== 8'd0) begin n_fail++; $display("FAIL walk_cnt: got %0d expected 0", bus.abort_cnt); end
  endtask

  task automatic test_dma_abort();
    bus.pc     = 16'hE010;
    bus.dma_en = 1'b1;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL dma_exec: got %b expected 00", bus.exec); end
    tick();
    bus.dma_en = 1'b0;
    n_checks++;
    if (bus.abort_cause[1:0] !== 2'b10) begin n_fail++; $display("FAIL dma_cause: got %b expected 10", bus.abort_cause[1:0]); end
    n_checks++;
    if (bus.abort_cnt !== 8'd1) begin n_fail++; $display("FAIL dma_cnt: got %0d expected 1", bus.abort_cnt); end
    bus.pc = 16'hE020;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL dma_stay_abort: got %b expected 00", bus.exec); end
    tick();
    bus.pc = 16'hE000;
    #1;
    n_checks++;
    if (bus.exec !== 2'b01) begin n_fail++; $display("FAIL dma_reentry: got %b expected 01", bus.exec); end
    tick();
    n_checks++;
    if (bus.abort_cause[1:0] !== 2'b00) begin n_fail++; $display("FAIL dma_cause_clear: got %b expected 00", bus.abort_cause[1:0]); end
  endtask

  task automatic test_irq_tolerance();
    bus.irq_allow = 2'b01;
    bus.irq       = 1'b1;
    bus.pc        = 16'hE050;
    #1;
    n_checks++;
    if (bus.exec !== 2'b01) begin n_fail++; $display("FAIL irq_allowed: got %b expected 01", bus.exec); end
    tick();
    bus.irq_allow = 2'b00;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL irq_blocked: got %b expected 00", bus.exec); end
    tick();
    bus.irq = 1'b0;
    n_checks++;
    if (bus.abort_cause[1:0] !== 2'b01) begin n_fail++; $display("FAIL irq_cause: got %b expected 01", bus.abort_cause[1:0]); end
    n_checks++;
    if (bus.abort_cnt !== 8'd2) begin n_fail++; $display("FAIL irq_cnt: got %0d expected 2", bus.abort_cnt); end
  endtask

  task automatic test_entry_violation();
    bus.pc        = 16'hF000;
    bus.irq       = 1'b1;
    bus.dma_en    = 1'b1;
    bus.irq_allow = 2'b00;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL entry_viol_exec: got %b expected 00", bus.exec); end
    tick();
    bus.irq    = 1'b0;
    bus.dma_en = 1'b0;
    bus.pc     = 16'hF001;
    #1;
    n_checks++;
    if (bus.exec[1] !== 1'b0) begin n_fail++; $display("FAIL entry_viol_state: got %b expected 0", bus.exec[1]); end
    n_checks++;
    if (bus.abort_cnt !== 8'd2) begin n_fail++; $display("FAIL entry_viol_cnt: got %0d expected 2", bus.abort_cnt); end
    n_checks++;
    if (bus.abort_cause[3:2] !== 2'b00) begin n_fail++; $display("FAIL entry_viol_cause: got %b expected 00", bus.abort_cause[3:2]); end
    tick();
  endtask

  task automatic test_counter_edges();
    for (int k = 0; k < 300; k++) begin
      bus.pc = 16'hE000;
      tick();
      bus.pc     = 16'hE001;
      bus.dma_en = 1'b1;
      tick();
      bus.dma_en = 1'b0;
    end
    n_checks++;
    if (bus.abort_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected 255", bus.abort_cnt); end
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    n_checks++;
    if (bus.abort_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", bus.abort_cnt); end
    bus.pc = 16'hE000;
    tick();
    bus.pc      = 16'hE001;
    bus.dma_en  = 1'b1;
    bus.cnt_clr = 1'b1;
    tick();
    bus.dma_en  = 1'b0;
    bus.cnt_clr = 1'b0;
    n_checks++;
    if (bus.abort_cnt !== 8'd1) begin n_fail++; $display("FAIL cnt_clear_abort: got %0d expected 1", bus.abort_cnt); end
  endtask

  task automatic test_simultaneous();
    bus.er_min[31:16] = 16'hE000;
    bus.er_max[31:16] = 16'hE0FF;
    bus.pc = 16'hE000;
    #1;
    n_checks++;
    if (bus.exec !== 2'b11) begin n_fail++; $display("FAIL sim_entry: got %b expected 11", bus.exec); end
    tick();
    bus.pc     = 16'hE005;
    bus.dma_en = 1'b1;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL sim_abort_exec: got %b expected 00", bus.exec); end
    tick();
    bus.dma_en = 1'b0;
    n_checks++;
    if (bus.abort_cnt !== 8'd2) begin n_fail++; $display("FAIL sim_cnt: got %0d expected 2", bus.abort_cnt); end
    n_checks++;
    if (bus.abort_cause !== 4'b1010) begin n_fail++; $display("FAIL sim_cause: got %b expected 1010", bus.abort_cause); end
  endtask

  task automatic test_reset_mid_exec();
    bus.er_min[31:16] = 16'hF000;
    bus.er_max[31:16] = 16'hF0FF;
    bus.pc = 16'hE000;
    tick();
    bus.pc = 16'hE001;
    #1;
    n_checks++;
    if (bus.exec !== 2'b01) begin n_fail++; $display("FAIL mid_exec_pre: got %b expected 01", bus.exec); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL mid_exec_forced: got %b expected 00", bus.exec); end
    n_checks++;
    if (bus.any_exec !== 1'b0) begin n_fail++; $display("FAIL mid_exec_any: got %b expected 0", bus.any_exec); end
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.abort_cause !== 4'b0000) begin n_fail++; $display("FAIL mid_exec_cause: got %b expected 0000", bus.abort_cause); end
    n_checks++;
    if (bus.abort_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_exec_cnt: got %0d expected 0", bus.abort_cnt); end
    bus.pc = 16'hE002;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL mid_exec_no_resume: got %b expected 00", bus.exec); end
    tick();
  endtask

  task automatic test_invalid_region();
    bus.pc = 16'hF000;
    #1;
    n_checks++;
    if (bus.exec !== 2'b10) begin n_fail++; $display("FAIL inv_enter_er1: got %b expected 10", bus.exec); end
    tick();
    bus.pc            = 16'hF001;
    bus.er_max[31:16] = 16'hEFFF;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL inv_exec_drop: got %b expected 00", bus.exec); end
    tick();
    bus.er_max[31:16] = 16'hF0FF;
    #1;
    n_checks++;
    if (bus.exec !== 2'b00) begin n_fail++; $display("FAIL inv_forced_abort: got %b expected 00", bus.exec); end
    tick();
    bus.er_min[31:16] = 16'hF100;
    bus.er_max[31:16] = 16'hF000;
    bus.pc            = 16'hF100;
    #1;
    n_checks++;
    if (bus.exec[1] !== 1'b0) begin n_fail++; $display("FAIL inv_min_gt_max: got %b expected 0", bus.exec[1]); end
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.pc        = 16'h0000;
    bus.irq       = 1'b0;
    bus.dma_en    = 1'b0;
    bus.irq_allow = 2'b00;
    bus.cnt_clr   = 1'b0;
    bus.er_min    = {16'hF000, 16'hE000};
    bus.er_max    = {16'hF0FF, 16'hE0FF};

    test_reset();
    test_entry_run();
    test_dma_abort();
    test_irq_tolerance();
    test_entry_violation();
    test_counter_edges();
    test_simultaneous();
    test_reset_mid_exec();
    test_invalid_region();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
